// File: rtl/controle_partida_pkg.sv
// Package: controle_partida_pkg
// Purpose: shared definitions for the werewolf game-flow controller. It holds the state
//          encoding (the numeric codes are the values shown on db_estado), the debug-code width
//          and the code shown for an illegal state.
package controle_partida_pkg;

    localparam int unsigned W_DB = 5;
    localparam logic [W_DB-1:0] DB_ERRO = 5'h1F;

    typedef enum logic [W_DB-1:0] {
        Inicial      = 5'd0,
        ResetaTudo   = 5'd1,
        PreparaJogo  = 5'd2,
        ArmazenaJogo = 5'd3,
        PreparaNoite = 5'd4,
        TurnoNoite   = 5'd5,
        ProximoNoite = 5'd6,
        PreparaDia   = 5'd7,
        TurnoDia     = 5'd8,
        ProximoDia   = 5'd9,
        FimRodada    = 5'd10,
        FimJogo      = 5'd11
    } estado_t;

    function automatic logic eh_turno(input estado_t e);
        return (e == TurnoNoite) || (e == TurnoDia);
    endfunction

endpackage

// File: rtl/busca_proximo_vivo.sv
// Module: busca_proximo_vivo
// Purpose: combinational search for the next living player.
//   vivo       in   N_JOGADORES  alive mask, bit i = player i alive
//   inicio     in   W_JOG        current player index
//   from_start in   1            1: lowest alive index overall; 0: lowest alive index > inicio
//   idx        out  W_JOG        index found (0 when none)
//   achou      out  1            a matching living player exists
module busca_proximo_vivo #(
    parameter int unsigned N_JOGADORES = 8,
    parameter int unsigned W_JOG       = $clog2(N_JOGADORES)
) (
    input  logic [N_JOGADORES-1:0] vivo,
    input  logic [W_JOG-1:0]       inicio,
    input  logic                   from_start,
    output logic [W_JOG-1:0]       idx,
    output logic                   achou
);

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        idx   = '0;
        achou = 1'b0;
        for (int i = N_JOGADORES - 1; i >= 0; i--) begin
            if (vivo[i] && (from_start || (i > int'(inicio)))) begin
                idx   = W_JOG'(i);
                achou = 1'b1;
            end
        end
    end

endmodule

// File: rtl/controle_partida.sv
// Module: controle_partida
// Purpose: game-flow FSM for the werewolf game. Captures the seed, then runs night and day
//          phases, giving one turn to each living player in index order, counts rounds and ends
//          the game on the datapath verdict or when the round limit is reached.
// Optional feature: define CONTROLE_TIMEOUT_EN to end a turn after TIMEOUT_CICLOS cycles
//          without a press (estourou flags such turns); otherwise estourou is tied low.
// Ports:
//   clock, reset (async, active high), jogar (start/restart level), passa (done button),
//   vivo (alive mask), fim_jogo (faction won) -> rst_global, zera_CS, e_seed_reg,
//   fase_noite, fase_dia, e_acao (action commit strobe), jogador_atual, rodada,
//   estourou (timeout strobe), pronto (game over), db_estado (state code).
module controle_partida
    import controle_partida_pkg::*;
#(
    parameter  int unsigned N_JOGADORES    = 8,
    parameter  int unsigned N_RODADAS_MAX  = 15,
    parameter  int unsigned TIMEOUT_CICLOS = 1000,
    localparam int unsigned W_JOG          = $clog2(N_JOGADORES),
    localparam int unsigned W_ROD          = $clog2(N_RODADAS_MAX + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   jogar,
    input  logic                   passa,
    input  logic [N_JOGADORES-1:0] vivo,
    input  logic                   fim_jogo,
    output logic                   rst_global,
    output logic                   zera_CS,
    output logic                   e_seed_reg,
    output logic                   fase_noite,
    output logic                   fase_dia,
    output logic                   e_acao,
    output logic [W_JOG-1:0]       jogador_atual,
    output logic [W_ROD-1:0]       rodada,
    output logic                   estourou,
    output logic                   pronto,
    output logic [W_DB-1:0]        db_estado
);

    estado_t          estado_q;
    logic [W_JOG-1:0] jogador_q;
    logic [W_ROD-1:0] rodada_q;
    logic             passa_q;

    logic             ev_passa;
    logic             expirou;
    logic             fim_ativo;
    logic             busca_inicio;
    logic [W_JOG-1:0] prox_idx;
    logic             prox_achou;
    logic [W_ROD-1:0] rodada_mais1;

    // One event per press: a held button never repeats.
    assign ev_passa     = passa & ~passa_q;
    assign fim_ativo    = (estado_q >= PreparaNoite) && (estado_q <= FimRodada);
    assign busca_inicio = (estado_q == PreparaNoite) || (estado_q == PreparaDia);
    assign rodada_mais1 = rodada_q + W_ROD'(1);

    busca_proximo_vivo #(
        .N_JOGADORES(N_JOGADORES)
    ) u_busca (
        .vivo      (vivo),
        .inicio    (jogador_q),
        .from_start(busca_inicio),
        .idx       (prox_idx),
        .achou     (prox_achou)
    );

`ifdef CONTROLE_TIMEOUT_EN
    localparam int unsigned W_TO = $clog2(TIMEOUT_CICLOS + 1);

    logic [W_TO-1:0] cont_q;
    logic            estourou_q;

    // A press in the last cycle of the turn takes precedence over the timeout.
    assign expirou = eh_turno(estado_q) && (cont_q == W_TO'(TIMEOUT_CICLOS - 1)) && !ev_passa;

    // Counter is zero on the first cycle of every turn since it clears outside TURNO states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q     <= '0;
            estourou_q <= 1'b0;
        end else begin
            cont_q     <= eh_turno(estado_q) ? cont_q + W_TO'(1) : '0;
            estourou_q <= expirou && !fim_jogo;
        end
    end

    assign estourou = estourou_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CICLOS;
    assign expirou        = 1'b0;
    assign estourou       = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= Inicial;
            jogador_q <= '0;
            rodada_q  <= '0;
            passa_q   <= 1'b0;
        end else begin
            passa_q <= passa;
            if (fim_ativo && fim_jogo) begin
                estado_q <= FimJogo;
            end else begin
                case (estado_q)
                    // Counters clear on entry so the reset state is visible in ResetaTudo.
                    Inicial, FimJogo: begin
                        if (jogar) begin
                            estado_q  <= ResetaTudo;
                            rodada_q  <= '0;
                            jogador_q <= '0;
                        end
                    end
                    ResetaTudo: begin
                        estado_q  <= PreparaJogo;
                        rodada_q  <= '0;
                        jogador_q <= '0;
                    end
                    PreparaJogo: if (ev_passa) estado_q <= ArmazenaJogo;
                    ArmazenaJogo: estado_q <= PreparaNoite;
                    PreparaNoite, PreparaDia: begin
                        if (!prox_achou) begin
                            estado_q <= FimJogo;
                        end else begin
                            jogador_q <= prox_idx;
                            estado_q  <= (estado_q == PreparaNoite) ? TurnoNoite : TurnoDia;
                        end
                    end
                    TurnoNoite: if (ev_passa || expirou) estado_q <= ProximoNoite;
                    TurnoDia:   if (ev_passa || expirou) estado_q <= ProximoDia;
                    ProximoNoite: begin
                        if (prox_achou) begin
                            jogador_q <= prox_idx;
                            estado_q  <= TurnoNoite;
                        end else begin
                            estado_q <= PreparaDia;
                        end
                    end
                    ProximoDia: begin
                        if (prox_achou) begin
                            jogador_q <= prox_idx;
                            estado_q  <= TurnoDia;
                        end else begin
                            estado_q <= FimRodada;
                        end
                    end
                    FimRodada: begin
                        rodada_q <= rodada_mais1;
                        estado_q <= (rodada_mais1 == W_ROD'(N_RODADAS_MAX)) ? FimJogo
                                                                             : PreparaNoite;
                    end
                    default: estado_q <= Inicial;
                endcase
            end
        end
    end

    assign rst_global    = (estado_q == Inicial) || (estado_q == ResetaTudo);
    assign zera_CS       = rst_global;
    assign e_seed_reg    = (estado_q == ArmazenaJogo);
    assign fase_noite    = (estado_q >= PreparaNoite) && (estado_q <= ProximoNoite);
    assign fase_dia      = (estado_q >= PreparaDia) && (estado_q <= ProximoDia);
    assign e_acao        = (estado_q == ProximoNoite) || (estado_q == ProximoDia);
    assign pronto        = (estado_q == FimJogo);
    assign jogador_atual = jogador_q;
    assign rodada        = rodada_q;
    assign db_estado     = (estado_q <= FimJogo) ? estado_q : DB_ERRO;

endmodule

// File: tb/tb_controle_partida.sv
// Bench for controle_partida: directed game scenarios, a behavioural game model compared every
// cycle, and hand-computed checkpoints.
module tb_controle_partida;

    localparam int NJ = 8;
    localparam int NR = 2;
    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       jogar = 1'b0;
    logic       passa = 1'b0;
    logic       fim_jogo = 1'b0;
    logic [7:0] vivo = 8'hFF;

    logic       rst_global, zera_cs, e_seed_reg, fase_noite, fase_dia, e_acao;
    logic       estourou, pronto;
    logic [2:0] jogador_atual;
    logic [1:0] rodada;
    logic [4:0] db_estado;

    controle_partida #(
        .N_JOGADORES   (NJ),
        .N_RODADAS_MAX (NR),
        .TIMEOUT_CICLOS(TO)
    ) dut (
        .clock        (clk),
        .reset        (rst),
        .jogar        (jogar),
        .passa        (passa),
        .vivo         (vivo),
        .fim_jogo     (fim_jogo),
        .rst_global   (rst_global),
        .zera_CS      (zera_cs),
        .e_seed_reg   (e_seed_reg),
        .fase_noite   (fase_noite),
        .fase_dia     (fase_dia),
        .e_acao       (e_acao),
        .jogador_atual(jogador_atual),
        .rodada       (rodada),
        .estourou     (estourou),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_seed  = 0;

    task automatic chk(input string nome, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_st, m_jog, m_rod, m_age;
    bit m_pd, m_est;

    // Lowest alive index strictly above lim (-1 = from the beginning); -1 when none.
    function automatic int proximo_vivo(input logic [7:0] v, input int lim);
        for (int i = lim + 1; i < NJ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : modelo
        int prox, a;
        bit ev, to;
        if (rst) begin
            m_st = 0; m_jog = 0; m_rod = 0; m_pd = 0; m_age = 0; m_est = 0;
        end else begin
            ev = passa && !m_pd;
            to = 0;
`ifdef CONTROLE_TIMEOUT_EN
            to = (m_st == 5 || m_st == 8) && (m_age == TO - 1) && !ev;
`endif
            prox  = m_st;
            m_est = 0;
            if (fim_jogo && m_st >= 4 && m_st <= 10) prox = 11;
            else begin
                case (m_st)
                    0, 11: if (jogar) begin prox = 1; m_rod = 0; m_jog = 0; end
                    1: prox = 2;
                    2: if (ev) prox = 3;
                    3: prox = 4;
                    4, 7: begin
                        a = proximo_vivo(vivo, -1);
                        if (a < 0) prox = 11;
                        else begin m_jog = a; prox = m_st + 1; end
                    end
                    5, 8: if (ev || to) begin prox = m_st + 1; m_est = to; end
                    6, 9: begin
                        a = proximo_vivo(vivo, m_jog);
                        if (a >= 0) begin m_jog = a; prox = m_st - 1; end
                        else prox = (m_st == 6) ? 7 : 10;
                    end
                    10: begin m_rod++; prox = (m_rod == NR) ? 11 : 4; end
                    default: prox = 0;
                endcase
            end
            m_age = ((prox == 5 || prox == 8) && prox == m_st) ? m_age + 1 : 0;
            m_st  = prox;
            m_pd  = passa;
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #3;
        if (e_seed_reg) n_seed++;
        chk("db_estado", db_estado, m_st);
        chk("jogador_atual", jogador_atual, m_jog);
        chk("rodada", rodada, m_rod);
        chk("rst_global", rst_global, int'(m_st <= 1));
        chk("zera_CS", zera_cs, int'(m_st <= 1));
        chk("e_seed_reg", e_seed_reg, int'(m_st == 3));
        chk("fase_noite", fase_noite, int'(m_st >= 4 && m_st <= 6));
        chk("fase_dia", fase_dia, int'(m_st >= 7 && m_st <= 9));
        chk("e_acao", e_acao, int'(m_st == 6 || m_st == 9));
        chk("pronto", pronto, int'(m_st == 11));
        chk("estourou", estourou, int'(m_est));
    end

    // ---------------- stimulus helpers ----------------
    task automatic pressiona();
        passa = 1'b1;
        @(negedge clk);
        passa = 1'b0;
        @(negedge clk);
    endtask

    // Presses whenever a press is awaited until the target state shows up, within lim steps.
    task automatic joga_ate(input int code, input int lim);
        int n;
        n = 0;
        while (db_estado !== code && n < lim) begin
            if (db_estado inside {5'd2, 5'd5, 5'd8}) pressiona();
            else @(negedge clk);
            n++;
        end
        chk($sformatf("reach_state_%0d", code), db_estado, code);
    endtask

    int esperado [3];
    int cnt;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_db", db_estado, 0);
        chk("rst_rst_global", rst_global, 1);
        chk("rst_jogador", jogador_atual, 0);
        chk("rst_rodada", rodada, 0);
        chk("rst_e_acao", e_acao, 0);
        rst = 1'b0;

        // 1: start sequence with everybody alive
        @(negedge clk); jogar = 1'b1;
        @(negedge clk); #1 chk("t1_reseta", db_estado, 1);
        jogar = 1'b0;
        @(negedge clk); #1 chk("t1_prepara_jogo", db_estado, 2);
        passa = 1'b1;
        @(negedge clk); #1 chk("t1_armazena", db_estado, 3);
        chk("t1_seed_on", e_seed_reg, 1);
        passa = 1'b0;
        @(negedge clk); #1 chk("t1_prepara_noite", db_estado, 4);
        chk("t1_seed_off", e_seed_reg, 0);
        @(negedge clk); #1 chk("t1_turno_noite", db_estado, 5);
        chk("t1_jogador", jogador_atual, 0);
        chk("t1_seed_count", n_seed, 1);

        // 2: sparse alive mask, night turns at 2, 5, 7
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; vivo = 8'b1010_0100; jogar = 1'b1;
        @(negedge clk); jogar = 1'b0;
        joga_ate(5, 20);
        chk("t2_first", jogador_atual, 2);
        esperado[0] = 2; esperado[1] = 5; esperado[2] = 7;
        for (int k = 0; k < 3; k++) begin
            passa = 1'b1;
            @(negedge clk); #1;
            chk($sformatf("t2_e_acao_%0d", k), e_acao, 1);
            chk($sformatf("t2_jogador_%0d", k), jogador_atual, esperado[k]);
            passa = 1'b0;
            @(negedge clk);
        end
        @(negedge clk); #1;
        chk("t2_fase_dia", fase_dia, 1);
        chk("t2_dia_jogador", jogador_atual, 2);
        chk("t2_turno_dia", db_estado, 8);

        // Finish the day; round 1 complete, back in a night turn
        joga_ate(5, 40);
        chk("t4_rodada1", rodada, 1);

`ifndef CONTROLE_TIMEOUT_EN
        // 3: held button yields one action only
        passa = 1'b1;
        cnt   = 0;
        repeat (50) begin
            @(negedge clk);
            if (e_acao) cnt++;
        end
        passa = 1'b0;
        @(negedge clk); #1;
        chk("t3_one_e_acao", cnt, 1);
        chk("t3_jogador", jogador_atual, 5);
`endif

        // 4: players 0/1 only remain; play to the round limit
        vivo = 8'h03;
        joga_ate(11, 80);
        chk("t4_rodada2", rodada, 2);
        chk("t4_pronto", pronto, 1);
        chk("t4_jogador", jogador_atual, 1);
        repeat (3) @(negedge clk);
        #1 chk("t4_hold", db_estado, 11);

        // 5: restart, then verdict during a day turn beats a press
        jogar = 1'b1;
        @(negedge clk); #1;
        chk("t5_reseta", db_estado, 1);
        chk("t5_rodada0", rodada, 0);
        chk("t5_jogador0", jogador_atual, 0);
        jogar = 1'b0;
        vivo  = 8'b1010_0100;
        joga_ate(8, 60);
        passa    = 1'b1;
        fim_jogo = 1'b1;
        @(negedge clk); #1;
        chk("t5_fim", db_estado, 11);
        chk("t5_no_e_acao", e_acao, 0);
        chk("t5_jogador_hold", jogador_atual, 2);
        passa    = 1'b0;
        fim_jogo = 1'b0;

        // 6: timeout (when built in), then reset in the middle of a turn
        vivo  = 8'hFF;
        jogar = 1'b1;
        @(negedge clk); jogar = 1'b0;
        joga_ate(5, 30);
`ifdef CONTROLE_TIMEOUT_EN
        repeat (9) @(negedge clk);
        #1 chk("t6_still_turno", db_estado, 5);
        @(negedge clk); #1;
        chk("t6_proximo", db_estado, 6);
        chk("t6_e_acao", e_acao, 1);
        chk("t6_estourou", estourou, 1);
        @(negedge clk); #1;
        chk("t6_estourou_off", estourou, 0);
        chk("t6_next_player", jogador_atual, 1);
`else
        pressiona();
        #1 chk("t6_next_player", jogador_atual, 1);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_db", db_estado, 0);
        chk("t6_rst_jogador", jogador_atual, 0);
        chk("t6_rst_rodada", rodada, 0);
        chk("t6_rst_e_acao", e_acao, 0);
        chk("t6_rst_estourou", estourou, 0);
        chk("t6_rst_pronto", pronto, 0);
        chk("t6_rst_global", rst_global, 1);
        chk("t6_rst_fase", {fase_noite, fase_dia}, 0);
        @(negedge clk); rst = 1'b0;

        // Nobody alive: the night cannot start
        vivo  = 8'h00;
        jogar = 1'b1;
        @(negedge clk); jogar = 1'b0;
        joga_ate(11, 20);
        chk("t7_pronto", pronto, 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
